// File: rtl/loba_acc.sv
`default_nettype none
// ============================================================================
// loba_acc : accumulates LEN unsigned approximate products (or fewer, ending
//            on in_last) into one result presented on a valid/ready output.
// Optional build macro: LOBA_ACC_SAT_EN (clamp on overflow instead of wrap).
// Revision : 1.0
// ============================================================================
module loba_acc #(
  parameter int N     = 16,
  parameter int ACC_W = 40,
  parameter int LEN   = 8,
  localparam int CNT_W = $clog2(LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*N-1:0]     in_p,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_sum,
  output logic [CNT_W-1:0]   out_cnt,
  output logic               out_ovf
);

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               ovf;

  logic [ACC_W:0]     sum_ext;
  logic               carry;
  logic               ovf_next;
  logic [ACC_W-1:0]   acc_next;
  logic [CNT_W-1:0]   cnt_next;
  logic               closes;

  // One extra bit captures the carry out of the accumulator MSB.
  assign sum_ext  = {1'b0, acc} + (ACC_W + 1)'(in_p);
  assign carry    = sum_ext[ACC_W];
  assign ovf_next = ovf | carry;
  assign cnt_next = cnt + CNT_W'(1);
  assign closes   = in_last || (cnt == CNT_LAST);

`ifdef LOBA_ACC_SAT_EN
  // Once overflow is seen the sum pins at all-ones until the group closes.
  assign acc_next = ovf_next ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
  assign acc_next = sum_ext[ACC_W-1:0];
`endif

  assign in_ready = (state == ST_ACC) && !clr && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_ACC;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cnt   <= '0;
      out_ovf   <= 1'b0;
    end else if (clr) begin
      state     <= ST_ACC;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          if (in_valid) begin
            if (closes) begin
              out_sum   <= acc_next;
              out_cnt   <= cnt_next;
              out_ovf   <= ovf_next;
              out_valid <= 1'b1;
              acc       <= '0;
              cnt       <= '0;
              ovf       <= 1'b0;
              state     <= ST_DONE;
            end else begin
              acc <= acc_next;
              cnt <= cnt_next;
              ovf <= ovf_next;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_ACC;
          end
        end
        default: begin
          state     <= ST_ACC;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_loba_acc.sv
`default_nettype none
// ============================================================================
// tb_loba_acc : scoreboard bench for loba_acc; two instances (LEN=8/ACC_W=40
//               and LEN=3/ACC_W=33) with randomized groups, clr and stalls.
// Revision : 1.0
// ============================================================================
module tb_loba_acc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  bit done [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int LG  = (gi == 0) ? 8 : 3;
    localparam int AW  = (gi == 0) ? 40 : 33;
    localparam int CWG = $clog2(LG + 1);

    logic            clr       = 1'b0;
    logic            in_valid  = 1'b0;
    logic            in_last   = 1'b0;
    logic            out_ready = 1'b0;
    logic [31:0]     in_p      = '0;
    logic            in_ready;
    logic            out_valid;
    logic [AW-1:0]   out_sum;
    logic [CWG-1:0]  out_cnt;
    logic            out_ovf;

    longint unsigned q_sum [$];
    int              q_cnt [$];
    bit              q_ovf [$];
    logic [31:0]     gq    [$];
    bit              bp = 1'b0;

    loba_acc #(.N(16), .ACC_W(AW), .LEN(LG)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_p      (in_p),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cnt   (out_cnt),
      .out_ovf   (out_ovf)
    );

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
      n_checks++;
      if (act != exp) begin
        n_fails++;
        $display("FAIL %s[inst%0d]: got 0x%0h, expected 0x%0h at %0t", name, gi, act, exp, $time);
      end
    endtask

    // Reference: products are non-negative, so overflow happened iff the
    // true total exceeds the accumulator range.
    task automatic push_exp(input longint unsigned tot, input int k);
      longint unsigned mx = (64'd1 << AW) - 64'd1;
      bit ov = (tot > mx);
      q_ovf.push_back(ov);
      q_cnt.push_back(k);
`ifdef LOBA_ACC_SAT_EN
      q_sum.push_back(ov ? mx : tot);
`else
      q_sum.push_back(tot & mx);
`endif
    endtask

    task automatic beat(input logic [31:0] p, input logic last, input logic closes);
      int t = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_p     = p;
      in_last  = last;
      while (!in_ready && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (t >= 300) begin
        chk("beat_timeout", 1, 0);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      if (closes) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("latency_out_valid", out_valid, 1);
      end
    endtask

    task automatic do_clr();
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      clr      = 1'b1;
      #1;
      chk("in_ready_during_clr", in_ready, 0);
      @(negedge clk);
      clr = 1'b0;
    endtask

    // Sends the beats in gq as one group; the closing beat pushes the expectation.
    task automatic send_group(input bit flag_last, input bit idles);
      longint unsigned tot = 0;
      int k = gq.size();
      for (int i = 0; i < k; i++) begin
        logic last   = (i == k - 1) && ((k < LG) || flag_last);
        logic closes = last || (i == LG - 1);
        tot += gq[i];
        if (closes) push_exp(tot, i + 1);
        beat(gq[i], last, closes);
        if (!closes && idles && ($urandom % 4 == 0)) begin
          @(negedge clk);
          in_valid = 1'b0;
        end
      end
      gq.delete();
    endtask

    task automatic clr_group(input int j);
      for (int i = 0; i < j; i++) beat($urandom, 1'b0, 1'b0);
      do_clr();
    endtask

    function automatic logic [31:0] rprod();
      case ($urandom % 4)
        0:       return 32'h0;
        1:       return 32'($urandom_range(0, 255));
        2:       return $urandom;
        default: return 32'hFFFF_FFFF;
      endcase
    endfunction

    // Monitor: owns out_ready, checks held results and pops the scoreboard.
    initial begin
      bit            hold = 1'b0;
      logic [AW-1:0] held_sum = '0;
      forever begin
        @(negedge clk);
        if (rst) begin
          out_ready = 1'b0;
          hold      = 1'b0;
        end else begin
          if (hold) begin
            chk("held_valid", out_valid, 1);
            chk("held_sum", out_sum, held_sum);
          end
          if (out_valid) chk("in_ready_while_done", in_ready, 0);
          out_ready = bp ? 1'b0 : ($urandom_range(0, 3) != 0);
          if (out_valid && out_ready) begin
            if (q_sum.size() == 0) begin
              chk("unexpected_result", 1, 0);
            end else begin
              chk("out_sum", out_sum, q_sum.pop_front());
              chk("out_cnt", out_cnt, q_cnt.pop_front());
              chk("out_ovf", out_ovf, q_ovf.pop_front());
            end
          end
          hold     = out_valid && !out_ready;
          held_sum = out_sum;
        end
      end
    end

    // Stimulus
    initial begin
      int t;
      wait (rst == 1'b0);
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_sum", out_sum, 0);
      chk("rst_out_cnt", out_cnt, 0);
      chk("rst_out_ovf", out_ovf, 0);
      chk("rst_in_ready", in_ready, 1);

      if (gi == 0) begin
        for (int i = 0; i < 8; i++) gq.push_back(32'h0001_0000);
        send_group(1'b0, 1'b0);
        gq = '{32'h10, 32'h20, 32'h30};
        send_group(1'b0, 1'b0);
      end else begin
        gq = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1};
        send_group(1'b1, 1'b0);
        gq = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h2};
        send_group(1'b1, 1'b0);
        gq = '{32'hFFFF_FFFF, 32'h0, 32'h0};
        send_group(1'b0, 1'b0);
      end

      // Backpressure: result held while the next group's first beat waits.
      bp = 1'b1;
      fork
        begin
          repeat (8) @(negedge clk);
          bp = 1'b0;
        end
      join_none
      gq = '{32'h1234, 32'h0};
      send_group(1'b0, 1'b0);
      gq = '{32'h9};
      send_group(1'b0, 1'b0);

      // Abort mid-group, then a single-beat group must start from zero.
      beat(32'h5, 1'b0, 1'b0);
      beat(32'h5, 1'b0, 1'b0);
      do_clr();
      gq = '{32'h7};
      send_group(1'b0, 1'b0);

      for (int g = 0; g < 60; g++) begin
        int r = $urandom % 10;
        if (r == 0) begin
          clr_group($urandom_range(1, LG - 1));
        end else begin
          int k = $urandom_range(1, LG);
          if (r == 1) begin
            bp = 1'b1;
            fork
              begin
                repeat ($urandom_range(2, 7)) @(negedge clk);
                bp = 1'b0;
              end
            join_none
          end
          for (int i = 0; i < k; i++) gq.push_back(rprod());
          send_group($urandom % 2 == 1, 1'b1);
        end
      end

      t = 0;
      while ((q_sum.size() != 0 || out_valid) && t < 500) begin
        @(negedge clk);
        t++;
      end
      if (t >= 500) chk("drain_timeout", 1, 0);
      done[gi] = 1'b1;
    end
  end

  initial begin
    int t = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    while (!(done[0] && done[1]) && t < 60000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 60000) begin
      n_checks++;
      n_fails++;
      $display("FAIL global_timeout: got %0d cycles, expected completion", t);
    end
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
